// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment capture path: active-low segment
// patterns (bit6=g .. bit0=a), decoded code values and the capture FSM states.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_DASH    = 4'd10;
   localparam logic [3:0] CODE_BLANK   = 4'd11;
   localparam logic [3:0] CODE_INVALID = 4'd15;

   typedef enum logic [1:0] {
      st_idle,
      st_settle,
      st_captured
   } cap_state_t;

endpackage

// File: rtl/sseg_to_code.sv
// Combinational decode of one active-low segment pattern back to its 4-bit code.
module sseg_to_code
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       invalid
);

   always_comb begin
      code    = CODE_INVALID;
      invalid = 1'b0;
      case (seg)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_DASH:  code = CODE_DASH;
         SEG_BLANK: code = CODE_BLANK;
         default:   invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/sseg_capture.sv
// Snoops a multiplexed active-low seven-segment bus and rebuilds per-digit codes.
//   state       | meaning
//   st_idle     | no single anode driven, counter held at 0
//   st_settle   | one anode low, counting cycles the (an, sseg) pair holds
//   st_captured | pattern written, waiting for the pair to change
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            sseg,
   input  logic [N_DIGITS-1:0]   an,
   output logic [4*N_DIGITS-1:0] bcd,
   output logic [N_DIGITS-1:0]   digit_valid,
   output logic                  upd,
   output logic                  err,
   output logic                  frame_done
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYCLES);

   logic [N_DIGITS-1:0] an_m, an_s, an_p, an_low, seen;
   logic [6:0]          sseg_m, sseg_s, sseg_p;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [3:0]          code;
   logic                invalid, one_hot, changed, cap;
   cap_state_t          state;

   sseg_to_code u_dec (
      .seg     (sseg_s),
      .code    (code),
      .invalid (invalid)
   );

   assign an_low  = ~an_s;
   assign one_hot = $onehot(an_low);
   assign changed = (an_s != an_p) || (sseg_s != sseg_p);

   // A changed pair always restarts the run at 1, so a new digit settles fresh.
   always_comb begin
      cnt_nxt = '0;
      case (state)
         st_settle:   cnt_nxt = changed ? (one_hot ? CW'(1) : '0)
                                        : ((cnt == CNT_TC) ? cnt : cnt + CW'(1));
         st_captured: cnt_nxt = changed ? (one_hot ? CW'(1) : '0) : cnt;
         default:     cnt_nxt = one_hot ? CW'(1) : '0;
      endcase
      cap = one_hot && (cnt_nxt == CNT_TC) && ((state != st_captured) || changed);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_m        <= '1;
         an_s        <= '1;
         an_p        <= '1;
         sseg_m      <= '1;
         sseg_s      <= '1;
         sseg_p      <= '1;
         state       <= st_idle;
         cnt         <= '0;
         seen        <= '0;
         bcd         <= '1;
         digit_valid <= '0;
         upd         <= 1'b0;
         err         <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         an_m       <= an;
         an_s       <= an_m;
         an_p       <= an_s;
         sseg_m     <= sseg;
         sseg_s     <= sseg_m;
         sseg_p     <= sseg_s;
         cnt        <= cnt_nxt;
         upd        <= 1'b0;
         err        <= 1'b0;
         frame_done <= 1'b0;

         if (cap)
            state <= st_captured;
         else if (cnt_nxt == '0)
            state <= st_idle;
         else if (state == st_idle || changed)
            state <= st_settle;

         if (cap) begin
            upd <= 1'b1;
            err <= invalid;
            for (int i = 0; i < N_DIGITS; i++) begin
               if (an_low[i]) begin
                  bcd[4*i +: 4]  <= code;
                  digit_valid[i] <= ~invalid;
               end
            end
            // The capture that completes the set reports the frame and starts a new one.
            if ((seen | an_low) == {N_DIGITS{1'b1}}) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen <= seen | an_low;
            end
         end
      end
   end

endmodule
